// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 constants, FSM state encoding and fault decode for the load/store unit.
package lsu_pkg;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} lsu_state_e;

   // Misaligned halfword/word, or a funct3 that has no RV32I load/store meaning.
   function automatic logic is_fault(input logic st, input logic [2:0] f3, input logic [1:0] off);
      logic mis, bad;
      mis = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
      bad = st ? (f3[2] || f3 == 3'b011) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      return mis || bad;
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication/byte-enable generation and load byte extraction/extension.
//   st_off_i/st_funct3_i/st_data_i -> st_wdata_o, st_wmask_o (store side)
//   ld_off_i/ld_funct3_i/rdata_i   -> ld_data_o (load side)
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  st_off_i,
   input  logic [2:0]  st_funct3_i,
   input  logic [31:0] st_data_i,
   input  logic [1:0]  ld_off_i,
   input  logic [2:0]  ld_funct3_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] st_wdata_o,
   output logic [3:0]  st_wmask_o,
   output logic [31:0] ld_data_o
);
   logic [31:0] sh;
   always_comb begin
      st_wdata_o = (st_funct3_i[1:0] == 2'b00) ? {4{st_data_i[7:0]}} :
                   (st_funct3_i[1:0] == 2'b01) ? {2{st_data_i[15:0]}} : st_data_i;
      st_wmask_o = (st_funct3_i[1:0] == 2'b00) ? 4'b0001 << st_off_i :
                   (st_funct3_i[1:0] == 2'b01) ? 4'b0011 << {st_off_i[1], 1'b0} : 4'b1111;
      sh = rdata_i >> {ld_off_i, 3'b000};
      ld_data_o = (ld_funct3_i == F3_LB)  ? {{24{sh[7]}}, sh[7:0]} :
                  (ld_funct3_i == F3_LH)  ? {{16{sh[15]}}, sh[15:0]} :
                  (ld_funct3_i == F3_LBU) ? {24'd0, sh[7:0]} :
                  (ld_funct3_i == F3_LHU) ? {16'd0, sh[15:0]} : sh;
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store unit between EX, a word memory and writeback.
//   in_*      op from EX (valid/ready, addr, wdata, funct3, is_store, rd)
//   mem_req_* word-aligned request (valid/ready, addr, wdata, wmask, we)
//   mem_resp_* load data, no backpressure
//   out_*     writeback (valid/ready, data, rd, we, fault)
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [2:0]  in_funct3,
   input  logic        in_is_store,
   input  logic [4:0]  in_rd,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   output logic        mem_we,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_rd,
   output logic        out_we,
   output logic        out_fault
);
   lsu_state_e  state_q;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic        st_q;
   logic [4:0]  rd_q;
   logic [31:0] st_wdata, ld_data;
   logic [3:0]  st_wmask;

   lsu_align u_align (
      .st_off_i    (in_addr[1:0]),
      .st_funct3_i (in_funct3),
      .st_data_i   (in_wdata),
      .ld_off_i    (off_q),
      .ld_funct3_i (f3_q),
      .rdata_i     (mem_rdata),
      .st_wdata_o  (st_wdata),
      .st_wmask_o  (st_wmask),
      .ld_data_o   (ld_data)
   );

   assign in_ready = state_q == S_IDLE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         off_q         <= 2'd0;
         f3_q          <= 3'd0;
         st_q          <= 1'b0;
         rd_q          <= 5'd0;
         mem_req_valid <= 1'b0;
         mem_addr      <= 32'd0;
         mem_wdata     <= 32'd0;
         mem_wmask     <= 4'd0;
         mem_we        <= 1'b0;
         out_valid     <= 1'b0;
         out_data      <= 32'd0;
         out_rd        <= 5'd0;
         out_we        <= 1'b0;
         out_fault     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               off_q <= in_addr[1:0];
               f3_q  <= in_funct3;
               st_q  <= in_is_store;
               rd_q  <= in_rd;
               // Faulting ops never touch memory; report straight to writeback.
               if (is_fault(in_is_store, in_funct3, in_addr[1:0])) begin
                  state_q   <= S_RESP;
                  out_valid <= 1'b1;
                  out_fault <= 1'b1;
                  out_we    <= 1'b0;
                  out_data  <= 32'd0;
                  out_rd    <= in_is_store ? 5'd0 : in_rd;
               end else begin
                  state_q       <= S_REQ;
                  mem_req_valid <= 1'b1;
                  mem_addr      <= {in_addr[31:2], 2'b00};
                  mem_we        <= in_is_store;
                  mem_wmask     <= in_is_store ? st_wmask : 4'd0;
                  mem_wdata     <= in_is_store ? st_wdata : 32'd0;
               end
            end
            S_REQ: if (mem_req_ready) begin
               mem_req_valid <= 1'b0;
               mem_we        <= 1'b0;
               mem_wmask     <= 4'd0;
               state_q       <= st_q ? S_RESP : S_WAIT;
               if (st_q) begin
                  out_valid <= 1'b1;
                  out_data  <= 32'd0;
                  out_rd    <= 5'd0;
                  out_we    <= 1'b0;
                  out_fault <= 1'b0;
               end
            end
            S_WAIT: if (mem_resp_valid) begin
               state_q   <= S_RESP;
               out_valid <= 1'b1;
               out_data  <= ld_data;
               out_rd    <= rd_q;
               out_we    <= rd_q != 5'd0;
               out_fault <= 1'b0;
            end
            S_RESP: if (out_ready) begin
               state_q   <= S_IDLE;
               out_valid <= 1'b0;
               out_we    <= 1'b0;
               out_fault <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule
